// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined RISC-V core.
//
// Owns the program counter, presents it as the byte address to a
// combinational instruction memory and captures the returned word into
// the IF/ID pipeline register. Handles stall, flush and control-flow
// redirect from later stages.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect raises a sticky misalign_fault and
//               parks the stage in HALT until reset.
//   undefined : redirect targets are masked to 4-byte alignment and
//               misalign_fault is tied to 0.
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-high reset
//   stall            hold PC and IF/ID
//   flush            replace IF/ID contents with a bubble
//   redirect_valid   taken branch/jump resolved downstream
//   redirect_target  new PC when redirect_valid
//   imem_addr        byte address to instruction memory (the PC register)
//   imem_instr       instruction word returned combinationally for imem_addr
//   if_id_pc         PC of the instruction in IF/ID
//   if_id_pc_plus4   if_id_pc + 4
//   if_id_instr      instruction in IF/ID
//   if_id_valid      IF/ID holds a real instruction
//   misalign_fault   sticky misaligned-redirect fault
//
// FSM
//   state   | meaning
//   RUN     | normal fetch
//   HALT    | misaligned redirect trapped; PC frozen, IF/ID bubbles

module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [63:0] if_id_pc,
  output logic [63:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        misalign_fault
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] ifid_pc_q, ifid_pc_d;
  logic [63:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        fault_q, fault_d;

  logic [63:0] pc_plus4;
  logic        trap_redirect;

  assign pc_plus4 = pc_q + 64'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap_redirect = redirect_valid && (redirect_target[1:0] != 2'b00);
`else
  assign trap_redirect = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    fault_d      = fault_q;

    if (state_q == ST_HALT) begin
      // Frozen until reset: PC holds, IF/ID bubbles regardless of inputs.
      ifid_pc_d    = 64'h0;
      ifid_pc4_d   = 64'h0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (redirect_valid) begin
      // Redirect beats stall for both the PC and IF/ID.
      if (trap_redirect) begin
        fault_d = 1'b1;
        state_d = ST_HALT;
      end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
        pc_d = redirect_target;
`else
        pc_d = redirect_target & ~64'd3;
`endif
      end
      ifid_pc_d    = 64'h0;
      ifid_pc4_d   = 64'h0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else begin
      if (!stall) begin
        pc_d = pc_plus4;
      end
      if (flush) begin
        ifid_pc_d    = 64'h0;
        ifid_pc4_d   = 64'h0;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end else if (!stall) begin
        ifid_pc_d    = pc_q;
        ifid_pc4_d   = pc_plus4;
        ifid_instr_d = imem_instr;
        ifid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 64'h0;
      ifid_pc4_q   <= 64'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      fault_q      <= fault_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_pc       = ifid_pc_q;
  assign if_id_pc_plus4 = ifid_pc4_q;
  assign if_id_instr    = ifid_instr_q;
  assign if_id_valid    = ifid_valid_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_fault = fault_q;
`else
  assign misalign_fault = 1'b0;
`endif

endmodule
